// File: rtl/dm_cache_ctrl_pkg.sv
// Shared memory-subsystem geometry and the cache controller state encoding.
package memory_sub_system_param;

    localparam int ADDR_LENGTH     = 16;
    localparam int INDEX_LENGTH    = 4;
    localparam int OFFSET_LENGTH   = 2;
    localparam int NUM_CACHE_LINES = 2 ** INDEX_LENGTH;
    localparam int CACHE_LINE_SIZE = 128;
    localparam int TAG_LENGTH      = ADDR_LENGTH - INDEX_LENGTH - OFFSET_LENGTH;
    localparam int WORD_WIDTH      = CACHE_LINE_SIZE >> OFFSET_LENGTH;

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        RESP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        WR_UPD,
        WR_REQ,
        WR_WAIT
    } cache_ctrl_state_t;

endpackage

// File: rtl/dm_cache_ctrl_tag_store.sv
// Per-line {valid, tag} storage: one write port, combinational read, valid bits cleared on reset.
module dm_tag_store #(
    parameter int NUM_LINES = 16,
    parameter int INDEX_W   = 4,
    parameter int TAG_W     = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [INDEX_W-1:0] widx,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [INDEX_W-1:0] ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag
);

    logic [NUM_LINES-1:0]            valid_q;
    logic [NUM_LINES-1:0][TAG_W-1:0] tag_q;

    // Tags need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
            tag_q[widx]   <= wtag;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of a line-wide data array.
module dm_cache_ctrl
    import memory_sub_system_param::*;
#(
    parameter int ADDR_LEN     = ADDR_LENGTH,
    parameter int INDEX_LEN    = INDEX_LENGTH,
    parameter int OFFSET_LEN   = OFFSET_LENGTH,
    parameter int NUM_CACHE_L  = NUM_CACHE_LINES,
    parameter int CACHE_L_SIZE = CACHE_LINE_SIZE,
    localparam int WORD_W      = CACHE_L_SIZE >> OFFSET_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_we,
    input  logic [ADDR_LEN-1:0]     cpu_addr,
    input  logic [WORD_W-1:0]       cpu_wdata,
    output logic                    cpu_rsp_valid,
    output logic [WORD_W-1:0]       cpu_rd_data,
    output logic                    cache_resetn,
    output logic                    cache_write,
    output logic [INDEX_LEN-1:0]    cache_index,
    output logic [OFFSET_LEN-1:0]   cache_offset,
    output logic [CACHE_L_SIZE-1:0] cache_din,
    input  logic [CACHE_L_SIZE-1:0] cache_dout,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [ADDR_LEN-1:0]     mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic                    mem_rsp_valid,
    input  logic [CACHE_L_SIZE-1:0] mem_rdata
);

    localparam int TAG_LEN = ADDR_LEN - INDEX_LEN - OFFSET_LEN;

    cache_ctrl_state_t state, nstate;

    logic [ADDR_LEN-1:0]     addr_q;
    logic                    we_q;
    logic [WORD_W-1:0]       wdata_q;
    logic [CACHE_L_SIZE-1:0] line_q;

    logic [TAG_LEN-1:0]    tag_q;
    logic [INDEX_LEN-1:0]  idx_q;
    logic [OFFSET_LEN-1:0] off_q;

    logic                    tag_we;
    logic                    ts_valid;
    logic [TAG_LEN-1:0]      ts_tag;
    logic                    hit;
    logic [WORD_W-1:0]       rd_word;
    logic [CACHE_L_SIZE-1:0] upd_line;

    assign tag_q = addr_q[ADDR_LEN-1 -: TAG_LEN];
    assign idx_q = addr_q[OFFSET_LEN +: INDEX_LEN];
    assign off_q = addr_q[OFFSET_LEN-1:0];

    dm_tag_store #(
        .NUM_LINES (NUM_CACHE_L),
        .INDEX_W   (INDEX_LEN),
        .TAG_W     (TAG_LEN)
    ) u_tag_store (
        .clk    (clk),
        .reset  (reset),
        .we     (tag_we),
        .widx   (idx_q),
        .wtag   (tag_q),
        .ridx   (idx_q),
        .rvalid (ts_valid),
        .rtag   (ts_tag)
    );

    assign hit = ts_valid && (ts_tag == tag_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && cpu_req_valid) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            // The array read issued at accept lands during LOOKUP.
            if (state == LOOKUP)
                line_q <= cache_dout;
            if (state == MISS_WAIT && mem_rsp_valid)
                line_q <= mem_rdata;
        end
    end

    always_comb begin
        rd_word  = line_q[int'(off_q)*WORD_W +: WORD_W];
        upd_line = line_q;
        upd_line[int'(off_q)*WORD_W +: WORD_W] = wdata_q;
    end

    // Array addressing follows the live request in IDLE so the read starts on the accept edge.
    assign cache_index  = (state == IDLE) ? cpu_addr[OFFSET_LEN +: INDEX_LEN] : idx_q;
    assign cache_offset = (state == IDLE) ? cpu_addr[OFFSET_LEN-1:0] : off_q;
    assign cache_resetn = ~reset;

    always_comb begin
        nstate        = state;
        cpu_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        cpu_rd_data   = '0;
        cache_write   = 1'b0;
        cache_din     = '0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        tag_we        = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) nstate = LOOKUP;
            end
            LOOKUP: begin
                case ({we_q, hit})
                    2'b01:   nstate = RESP;
                    2'b00:   nstate = MISS_REQ;
                    2'b11:   nstate = WR_UPD;
                    default: nstate = WR_REQ;
                endcase
            end
            RESP: begin
                cpu_rsp_valid = 1'b1;
                if (!we_q) cpu_rd_data = rd_word;
                nstate = IDLE;
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {tag_q, idx_q, {OFFSET_LEN{1'b0}}};
                if (mem_req_ready) nstate = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) nstate = FILL;
            end
            FILL: begin
                cache_write   = 1'b1;
                cache_din     = line_q;
                tag_we        = 1'b1;
                cpu_rsp_valid = 1'b1;
                cpu_rd_data   = rd_word;
                nstate        = IDLE;
            end
            WR_UPD: begin
                cache_write = 1'b1;
                cache_din   = upd_line;
                nstate      = WR_REQ;
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                if (mem_req_ready) nstate = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_rsp_valid) nstate = RESP;
            end
            default: nstate = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a behavioural data array and a scripted memory responder.
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_valid, cpu_req_ready, cpu_we;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_rsp_valid;
    logic [31:0]  cpu_rd_data;
    logic         cache_resetn, cache_write;
    logic [3:0]   cache_index;
    logic [1:0]   cache_offset;
    logic [127:0] cache_din, cache_dout;
    logic         mem_req_valid, mem_req_ready, mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_rsp_valid;
    logic [127:0] mem_rdata;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rd_data(cpu_rd_data),
        .cache_resetn(cache_resetn), .cache_write(cache_write), .cache_index(cache_index),
        .cache_offset(cache_offset), .cache_din(cache_din), .cache_dout(cache_dout),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    // Registered-read data array
    logic [127:0] arr [16];
    always @(posedge clk) begin
        if (cache_write) arr[cache_index] <= cache_din;
        else             cache_dout <= arr[cache_index];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observations from the last transaction
    int           n_req, n_cw, rsp_cyc;
    logic         got_rsp, req_we, stable;
    logic [15:0]  req_addr;
    logic [31:0]  req_wdata, rsp_data;
    logic [3:0]   cw_idx;
    logic [127:0] cw_din;

    // Starts at a negedge with the FSM idle; ends at the negedge after the response.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [127:0] line, input int ready_delay, input logic early);
        int cyc, phase, dly;
        for (int i = 0; i < 20 && !cpu_req_ready; i++) @(negedge clk);
        chk("accept_ready", cpu_req_ready, 1'b1);
        cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cyc = 1; phase = 0; dly = 0;
        n_req = 0; n_cw = 0; got_rsp = 1'b0; stable = 1'b1; rsp_cyc = -1;
        req_addr = '0; req_we = 1'b0; req_wdata = '0; rsp_data = '0; cw_idx = '0; cw_din = '0;
        for (int i = 0; i < 40 && !got_rsp; i++) begin
            if (cache_write) begin n_cw++; cw_idx = cache_index; cw_din = cache_din; end
            if (cpu_rsp_valid) begin got_rsp = 1'b1; rsp_data = cpu_rd_data; rsp_cyc = cyc; end
            if (mem_req_valid) begin
                if (n_req == 0) begin
                    req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
                end else if (mem_addr !== req_addr || mem_we !== req_we) begin
                    stable = 1'b0;
                end
                if (cpu_req_ready) stable = 1'b0;
                n_req++;
            end
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            case (phase)
                0: if (mem_req_valid) begin
                       if (dly == ready_delay) begin
                           mem_req_ready = 1'b1; phase = 1;
                           if (early) begin mem_rsp_valid = 1'b1; mem_rdata = ~line; end
                       end else dly++;
                   end
                1: begin mem_rsp_valid = 1'b1; mem_rdata = line; phase = 2; end
                default: ;
            endcase
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        chk("rsp_seen", got_rsp, 1'b1);
    endtask

    localparam logic [127:0] L1 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [127:0] L1W = {32'hDDDD0003, 32'hCAFEF00D, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [127:0] L2 = {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000};
    localparam logic [127:0] L3 = {32'h11110003, 32'h11110002, 32'h11110001, 32'h11110000};

    initial begin
        logic bad;
        for (int i = 0; i < 16; i++) arr[i] = '0;
        reset = 1'b1; cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", cpu_rsp_valid, 1'b0);
        chk("rst_cache_write", cache_write, 1'b0);
        chk("rst_mem_req", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_cache_resetn", cache_resetn, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cpu_req_ready, 1'b1);
        chk("post_rst_cache_resetn", cache_resetn, 1'b1);

        // Cold read miss: addr 0x0123 -> tag 0x004, index 8, offset 3
        run_txn(1'b0, 16'h0123, '0, L1, 0, 1'b0);
        chk("cold_req_addr", req_addr, 16'h0120);
        chk("cold_req_we", req_we, 1'b0);
        chk("cold_cw_cnt", n_cw, 1);
        chk("cold_cw_idx", cw_idx, 4'd8);
        chk("cold_cw_din", cw_din, L1);
        chk("cold_rsp", rsp_data, 32'hDDDD0003);
        chk("cold_rsp_cyc", rsp_cyc, 4);

        run_txn(1'b0, 16'h0121, '0, '0, 0, 1'b0);
        chk("hit_no_req", n_req, 0);
        chk("hit_rsp", rsp_data, 32'hBBBB0001);
        chk("hit_rsp_cyc", rsp_cyc, 2);

        run_txn(1'b1, 16'h0122, 32'hCAFEF00D, '0, 0, 1'b0);
        chk("wrhit_cw_cnt", n_cw, 1);
        chk("wrhit_cw_din", cw_din, L1W);
        chk("wrhit_req_addr", req_addr, 16'h0122);
        chk("wrhit_req_we", req_we, 1'b1);
        chk("wrhit_req_wdata", req_wdata, 32'hCAFEF00D);
        chk("wrhit_rsp_data", rsp_data, 32'h0);
        chk("wrhit_rsp_cyc", rsp_cyc, 5);

        run_txn(1'b0, 16'h0122, '0, '0, 0, 1'b0);
        chk("rd_after_wr_no_req", n_req, 0);
        chk("rd_after_wr", rsp_data, 32'hCAFEF00D);

        // 0x7F30: index 12, not resident
        run_txn(1'b1, 16'h7F30, 32'h12345678, '0, 0, 1'b0);
        chk("wrmiss_cw_cnt", n_cw, 0);
        chk("wrmiss_req_addr", req_addr, 16'h7F30);
        chk("wrmiss_req_we", req_we, 1'b1);
        chk("wrmiss_req_wdata", req_wdata, 32'h12345678);

        run_txn(1'b0, 16'h7F30, '0, L2, 0, 1'b0);
        chk("no_alloc_miss", n_req > 0, 1'b1);
        chk("no_alloc_req_addr", req_addr, 16'h7F30);
        chk("no_alloc_rsp", rsp_data, 32'h77770000);

        // Conflict on index 8 (tag 0x044); a same-edge rsp with ready must be ignored
        run_txn(1'b0, 16'h1120, '0, L3, 0, 1'b1);
        chk("conf_req_addr", req_addr, 16'h1120);
        chk("conf_cw_idx", cw_idx, 4'd8);
        chk("conf_rsp_not_early", rsp_data, 32'h11110000);
        chk("conf_rsp_cyc", rsp_cyc, 4);

        run_txn(1'b0, 16'h0120, '0, L1, 0, 1'b0);
        chk("reread_miss", n_req > 0, 1'b1);
        chk("reread_rsp", rsp_data, 32'hAAAA0000);

        run_txn(1'b0, 16'h0121, '0, '0, 0, 1'b0);
        chk("refill_hit_no_req", n_req, 0);

        // Reset while waiting for a line, then a stale response
        cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0161;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req_valid; i++) @(negedge clk);
        chk("rstmid_req_seen", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_mem_req", mem_req_valid, 1'b0);
        chk("rstmid_ready", cpu_req_ready, 1'b1);
        mem_rsp_valid = 1'b1; mem_rdata = ~L1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (cache_write || cpu_rsp_valid) bad = 1'b1;
        end
        chk("rstmid_stale_ignored", bad, 1'b0);

        // Valid bits were cleared; memory held off for 5 cycles
        run_txn(1'b0, 16'h0121, '0, L1, 5, 1'b0);
        chk("post_rst_miss", n_req > 0, 1'b1);
        chk("stall_cycles", n_req, 6);
        chk("stall_stable", stable, 1'b1);
        chk("stall_req_addr", req_addr, 16'h0120);
        chk("stall_rsp", rsp_data, 32'hBBBB0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
